// File: rtl/seq_comple2_unit.sv
// seq_comple2_unit: multi-cycle R = (A ^ {WIDTH{cmp}}) + Cin, CHUNK bits per clock.
// Carry is held in a register between chunks; start/busy/done handshake.
// Optional signed-overflow output enabled by defining COMPLE2_OVF_EN.
module seq_comple2_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic             Cin,
  input  logic             cmp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             Co
`ifdef COMPLE2_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmp_q, cmp_d;
  logic [WIDTH-1:0] op_q, op_d;    // operand, shifted down one chunk per RUN edge
  logic [WIDTH-1:0] acc_q, acc_d;  // result bits, shifted in from the top
  logic [WIDTH-1:0] r_q, r_d;
  logic             co_q, co_d;

  logic [CHUNK-1:0] ch_r;
  logic             ch_co;
  logic             ch_ctop;       // carry into the chunk's top bit (bit WIDTH-1 on the last chunk)

  // Ripple through the current chunk, starting from the held carry
  always_comb begin
    logic c, x;
    ch_r    = '0;
    ch_ctop = 1'b0;
    c       = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      x       = op_q[i] ^ cmp_q;
      ch_r[i] = x ^ c;
      if (i == CHUNK - 1) ch_ctop = c;
      c       = x & c;
    end
    ch_co = c;
  end

`ifdef COMPLE2_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cmp_d   = cmp_q;
    op_d    = op_q;
    acc_d   = acc_q;
    r_d     = r_q;
    co_d    = co_q;
`ifdef COMPLE2_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = A;
          cmp_d   = cmp;
          carry_d = Cin;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        op_d    = op_q >> CHUNK;
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(ch_r) << (WIDTH - CHUNK));
        carry_d = ch_co;
        if (cnt_q == CW'(N - 1)) begin
          r_d     = acc_d;
          co_d    = ch_co;
`ifdef COMPLE2_OVF_EN
          ovf_d   = ch_ctop ^ ch_co;
`endif
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, all cleared by async reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmp_q   <= 1'b0;
      op_q    <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cmp_q   <= cmp_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      co_q    <= co_d;
    end
  end

`ifdef COMPLE2_OVF_EN
  // Overflow flag, registered alongside Co
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`else
  logic unused_ctop;
  assign unused_ctop = ch_ctop;
`endif

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign R    = r_q;
  assign Co   = co_q;

endmodule

// File: tb/tb_seq_comple2_unit.sv
// Bench for seq_comple2_unit (WIDTH=16, CHUNK=4): cycle model + literal checks.
module tb_seq_comple2_unit;
  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic         Cin = 1'b0;
  logic         cmp = 1'b0;
  logic         busy, done, Co;
  logic [W-1:0] R;
`ifdef COMPLE2_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  seq_comple2_unit #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .Cin(Cin), .cmp(cmp),
    .busy(busy), .done(done), .R(R), .Co(Co)
`ifdef COMPLE2_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: t = edges since the accepting edge (-1 when idle)
  int           t = -1;
  logic [W-1:0] m_r = '0, p_r = '0;
  logic         m_co = 1'b0, p_co = 1'b0;
  logic         m_ovf = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] x;
    logic [W:0]   sum;
    if (rst) begin
      t = -1; m_r = '0; m_co = 1'b0; m_ovf = 1'b0;
    end else if (t < 0) begin
      if (start) begin
        x     = A ^ {W{cmp}};
        sum   = {1'b0, x} + (W+1)'(Cin);
        p_r   = sum[W-1:0];
        p_co  = sum[W];
        p_ovf = !x[W-1] && sum[W-1];
        t     = 0;
      end
    end else if (t < N) begin
      t++;
      if (t == N) begin m_r = p_r; m_co = p_co; m_ovf = p_ovf; end
    end else begin
      t = -1;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(t >= 0 && t < N));
      chk("done", 32'(done), 32'(t == N));
      chk("R",    32'(R),    32'(m_r));
      chk("Co",   32'(Co),   32'(m_co));
`ifdef COMPLE2_OVF_EN
      chk("ovf",  32'(ovf),  32'(m_ovf));
`endif
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic c, input logic ci,
                       input logic [W-1:0] er, input logic eco, input logic eovf, input string nm);
    int lat;
    @(negedge clk); start = 1'b1; A = a; cmp = c; Cin = ci;
    @(negedge clk); start = 1'b0; A = W'($urandom); cmp = 1'($urandom); Cin = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_lat"}, 32'(lat), 32'(N + 1));
    chk({nm, "_R"},   32'(R),   32'(er));
    chk({nm, "_Co"},  32'(Co),  32'(eco));
`ifdef COMPLE2_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unexpected x");
`endif
  endtask

  initial begin
    int         ndone;
    logic [W-1:0] cap_r;
    logic       cap_co, prev_done;

    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_R",    32'(R),    0);
    chk("rst_Co",   32'(Co),   0);
    @(negedge clk); #2 rst = 1'b0;

    // Literal expectations
    do_op(16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "t1");
    do_op(16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, "t2a");
    do_op(16'h8000, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, "t2b");
    do_op(16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "t3a");
    do_op(16'h7FFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, "t3b");
    do_op(16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 1'b0, 1'b0, "pass");
    do_op(16'hA5C3, 1'b1, 1'b0, 16'h5A3C, 1'b0, 1'b0, "ones");

    // start during RUN is ignored
    @(negedge clk); start = 1'b1; A = 16'h1234; cmp = 1'b1; Cin = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; A = 16'h0001;
    @(negedge clk); start = 1'b0;
    ndone = 0; cap_r = '0; cap_co = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) begin ndone++; cap_r = R; cap_co = Co; end
    end
    chk("t4_ndone", 32'(ndone), 1);
    chk("t4_R",     32'(cap_r), 32'h EDCC);
    chk("t4_Co",    32'(cap_co), 0);

    // Async reset in the middle of RUN
    @(negedge clk); start = 1'b1; A = 16'h4321; cmp = 1'b1; Cin = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_R",    32'(R),    0);
    chk("t5_Co",   32'(Co),   0);
    @(negedge clk); #2 rst = 1'b0;
    do_op(16'h00FF, 1'b1, 1'b0, 16'hFF00, 1'b0, 1'b0, "t5");

    // start held high: one result every N+2 cycles
    @(negedge clk); start = 1'b1; A = 16'h0003; cmp = 1'b1; Cin = 1'b1;
    ndone = 0; prev_done = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("t6_R", 32'(R), 32'hFFFD);
        chk("t6_gap", 32'(prev_done), 0);
      end
      prev_done = done;
    end
    chk("t6_ndone", 32'(ndone), 5);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Randomized traffic, including boundary operands
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: A = 16'h0000;
        1: A = 16'hFFFF;
        2: A = 16'h8000;
        3: A = 16'h7FFF;
        default: A = W'($urandom);
      endcase
      cmp = 1'($urandom);
      Cin = 1'($urandom);
    end
    start = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
